// File: rtl/fp16_addsub_seq.sv
// fp16_addsub_seq
//   Issue/return sequencer for an external fixed-latency FP16 add/sub pipeline.
//   A request is registered and issued to the pipeline one cycle after it is
//   accepted. A valid/tag shift register follows each operation through the
//   pipeline. When the operation reaches the tail, the raw pipeline result and
//   its tag are written into an in-order result FIFO. Credit counts operations
//   in flight plus results buffered, so a capture never meets a full FIFO.
//   FP16 values pass through untouched.
//
// Ports
//   clk, rst                   clock; asynchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_a, in_b, in_sub, in_tag request operands (x, y, 1 = x-y) and tag
//   pipe_arg_0/1/2, pipe_issue operands and one-cycle strobe to the pipeline
//   pipe_ret                   pipeline result, valid LATENCY cycles after issue
//   out_valid/out_ready        result handshake
//   out_data, out_tag          FIFO head result and its tag
//   busy                       anything issued, in flight or buffered
module fp16_addsub_seq #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic [15:0]      pipe_arg_0,
  output logic [15:0]      pipe_arg_1,
  output logic             pipe_arg_2,
  output logic             pipe_issue,
  input  logic [15:0]      pipe_ret,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);

  logic             accept;
  logic             capture;
  logic             pop;

  logic             issue_q;
  logic [15:0]      arg_a_q;
  logic [15:0]      arg_b_q;
  logic             arg_sub_q;
  logic [TAG_W-1:0] arg_tag_q;

  logic [LATENCY-1:0] vld_sr;
  logic [TAG_W-1:0]   tag_sr [LATENCY];

  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_used;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [15:0]      data_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];

  // NOTE: in_ready depends only on registered counters (and rst), never on
  // in_valid or out_ready. This keeps both handshakes free of combinational
  // loops. The cost is that a pop frees its credit one cycle later.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign in_ready    = !rst && (credit_used < CREDIT_MAX);
  assign accept      = in_valid && in_ready;
  assign capture     = vld_sr[LATENCY-1];
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;

  // The storage array has no reset, so the head is forced to zero while the
  // FIFO is empty. This makes out_data/out_tag read 0 during and after reset.
  assign out_data = out_valid ? data_mem[rd_ptr] : '0;
  assign out_tag  = out_valid ? tag_mem[rd_ptr]  : '0;

  // outstanding is counted from accept, so it already covers an issue pending
  // for the next cycle. issue_q is OR-ed in anyway to make the intent explicit.
  assign busy = (outstanding != '0) || (count != '0) || issue_q;

  assign pipe_issue = issue_q;
  assign pipe_arg_0 = arg_a_q;
  assign pipe_arg_1 = arg_b_q;
  assign pipe_arg_2 = arg_sub_q;

  // Issue stage: operand registers hold their last values between issues.
  // NOTE: every clocked block uses non-blocking assignments. All registers
  // then sample pre-edge values, whatever the order in which blocks run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q   <= 1'b0;
      arg_a_q   <= '0;
      arg_b_q   <= '0;
      arg_sub_q <= 1'b0;
      arg_tag_q <= '0;
    end else begin
      issue_q <= accept;
      if (accept) begin
        arg_a_q   <= in_a;
        arg_b_q   <= in_b;
        arg_sub_q <= in_sub;
        arg_tag_q <= in_tag;
      end
    end
  end

  // Shadow of the external pipeline. Stage 0 is loaded from the issue cycle,
  // so the tail is valid exactly when pipe_ret carries the matching result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
      for (int i = 0; i < LATENCY; i++) tag_sr[i] <= '0;
    end else begin
      vld_sr[0] <= issue_q;
      tag_sr[0] <= arg_tag_q;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  // Counters and pointers. Simultaneous events cancel, so nothing is lost
  // when accept, capture and pop coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      case ({accept, capture})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      case ({capture, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (capture) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the FIFO storage is deliberately not reset. Its contents are
  // meaningless while count is zero, and the outputs are gated above.
  always_ff @(posedge clk) begin
    if (capture) begin
      data_mem[wr_ptr] <= pipe_ret;
      tag_mem[wr_ptr]  <= tag_sr[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_fp16_addsub_seq.sv
// tb_fp16_addsub_seq
//   Directed bench for fp16_addsub_seq. It drives pipe_ret from a LATENCY-cycle
//   FP16 add/sub model of pipe_arg_*. Expected results are hand-computed.
module tb_fp16_addsub_seq;

  localparam int LATENCY = 5;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_a = '0;
  logic [15:0]      in_b = '0;
  logic             in_sub = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [15:0]      pipe_arg_0;
  logic [15:0]      pipe_arg_1;
  logic             pipe_arg_2;
  logic             pipe_issue;
  logic [15:0]      pipe_ret;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  always #5 clk = ~clk;

  fp16_addsub_seq #(
    .LATENCY(LATENCY),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .pipe_arg_0(pipe_arg_0),
    .pipe_arg_1(pipe_arg_1),
    .pipe_arg_2(pipe_arg_2),
    .pipe_issue(pipe_issue),
    .pipe_ret  (pipe_ret),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- golden FP16 model (normal numbers) ----------------
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    int  e;
    int  m;
    real mag;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 0) mag = m * pow2(-24);
    else        mag = (1024 + m) * pow2(e - 25);
    return h[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real r);
    logic s;
    real  a;
    int   e;
    int   m;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    return {s, 5'(e + 15), 10'(m)};
  endfunction

  function automatic logic [15:0] fp16_op(input logic [15:0] x, input logic [15:0] y, input logic sub);
    real ry;
    ry = fp16_to_real(y);
    return real_to_fp16(fp16_to_real(x) + (sub ? -ry : ry));
  endfunction

  // Pipeline model: not reset, so results of pre-reset issues still arrive late.
  logic [15:0] model_q [LATENCY];
  always @(posedge clk) begin
    for (int i = LATENCY - 1; i > 0; i--) model_q[i] <= model_q[i-1];
    model_q[0] <= pipe_issue ? fp16_op(pipe_arg_0, pipe_arg_1, pipe_arg_2) : 16'hDEAD;
  end
  assign pipe_ret = model_q[LATENCY-1];

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic drive_vec(input int i, input logic [TAG_W-1:0] tag);
    in_a   = vecs[i].a;
    in_b   = vecs[i].b;
    in_sub = vecs[i].sub;
    in_tag = tag;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
    while (!in_ready && n < 50) begin cycle(); n++; end
    check("send_ready", 32'(in_ready), 1);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [15:0] data, input logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 30) begin cycle(); n++; end
    check({name, "_valid"}, 32'(out_valid), 1);
    if (out_valid) begin
      check({name, "_data"}, 32'(out_data), 32'(data));
      check({name, "_tag"},  32'(out_tag),  32'(tag));
      cycle();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx_in;
    int idx_out;
    int cyc;
    int n;

    vecs[0] = '{16'h3C00, 16'h4000, 1'b0, 16'h4200};  // 1 + 2 = 3
    vecs[1] = '{16'h4200, 16'h3C00, 1'b1, 16'h4000};  // 3 - 1 = 2
    vecs[2] = '{16'h4000, 16'h4000, 1'b0, 16'h4400};  // 2 + 2 = 4
    vecs[3] = '{16'h4400, 16'h4200, 1'b1, 16'h3C00};  // 4 - 3 = 1
    vecs[4] = '{16'h3800, 16'h3800, 1'b0, 16'h3C00};  // 0.5 + 0.5 = 1
    vecs[5] = '{16'h4500, 16'h3C00, 1'b0, 16'h4600};  // 5 + 1 = 6
    vecs[6] = '{16'h3C00, 16'h4000, 1'b1, 16'hBC00};  // 1 - 2 = -1
    vecs[7] = '{16'h4800, 16'h4000, 1'b1, 16'h4600};  // 8 - 2 = 6

    // ---- reset state ----
    #1;
    check("rst_in_ready",   32'(in_ready),   0);
    check("rst_pipe_issue", 32'(pipe_issue), 0);
    check("rst_out_valid",  32'(out_valid),  0);
    check("rst_busy",       32'(busy),       0);
    check("rst_arg0",       32'(pipe_arg_0), 0);
    check("rst_out_data",   32'(out_data),   0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 1);
    cycle();

    // ---- single op: accept at T ----
    in_valid = 1'b1;
    drive_vec(0, 4'd3);
    check("single_in_ready", 32'(in_ready), 1);
    cycle();  // T+1
    in_valid = 1'b0;
    check("single_issue", 32'(pipe_issue), 1);
    check("single_arg0",  32'(pipe_arg_0), 32'h3C00);
    check("single_arg1",  32'(pipe_arg_1), 32'h4000);
    check("single_arg2",  32'(pipe_arg_2), 0);
    check("single_busy",  32'(busy),       1);
    cycle();  // T+2
    check("single_issue_low", 32'(pipe_issue), 0);
    check("single_arg_hold",  32'(pipe_arg_0), 32'h3C00);
    check("single_early_t2",  32'(out_valid),  0);
    for (int k = 3; k <= 6; k++) begin
      cycle();
      check($sformatf("single_early_t%0d", k), 32'(out_valid), 0);
    end
    cycle();  // T+7
    check("single_valid_t7", 32'(out_valid), 1);
    check("single_data",     32'(out_data),  32'h4200);
    check("single_tag",      32'(out_tag),   3);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("single_empty", 32'(out_valid), 0);
    check("single_idle",  32'(busy),      0);

    // ---- subtract ----
    send(16'h4200, 16'h3C00, 1'b1, 4'd5);
    pop_expect("sub", 16'h4000, 4'd5);

    // ---- hold with out_ready low ----
    send(16'h4400, 16'h4200, 1'b1, 4'd9);
    n = 0;
    while (!out_valid && n < 30) begin cycle(); n++; end
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", 32'(out_valid), 1);
      check("hold_data",  32'(out_data),  32'h3C00);
      check("hold_tag",   32'(out_tag),   9);
      cycle();
    end
    pop_expect("hold_pop", 16'h3C00, 4'd9);

    // ---- credit stall: 5 back-to-back requests, consumer stalled ----
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_vec(i, 4'(i));
      check($sformatf("stall_ready%0d", i), 32'(in_ready), 1);
      cycle();
    end
    drive_vec(4, 4'd4);
    check("stall_full", 32'(in_ready), 0);
    for (int k = 0; k < 10; k++) begin
      check("stall_blocked", 32'(in_ready), 0);
      cycle();
    end
    check("stall_head_valid", 32'(out_valid), 1);
    check("stall_head_tag",   32'(out_tag),   0);
    check("stall_head_data",  32'(out_data),  32'(vecs[0].exp));
    out_ready = 1'b1;
    cycle();  // one pop
    out_ready = 1'b0;
    check("stall_reopen", 32'(in_ready), 1);
    cycle();  // tag 4 accepted on that edge
    in_valid = 1'b0;
    check("stall_refull", 32'(in_ready), 0);
    for (int i = 1; i < 5; i++)
      pop_expect($sformatf("stall_pop%0d", i), vecs[i].exp, 4'(i));
    check("stall_idle", 32'(busy), 0);

    // ---- simultaneous accept/capture/pop, steady stream ----
    idx_in = 0;
    idx_out = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (idx_out < 8 && cyc < 100) begin
      in_valid = (idx_in < 8);
      if (idx_in < 8) drive_vec(idx_in, 4'(8 + idx_in));
      if (cyc == 4) check("stream_b2b", 32'(idx_in), 4);
      if (out_valid) begin
        check($sformatf("stream_data%0d", idx_out), 32'(out_data), 32'(vecs[idx_out].exp));
        check($sformatf("stream_tag%0d", idx_out),  32'(out_tag),  32'(8 + idx_out));
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
      cycle();
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", 32'(idx_out), 8);
    for (int k = 0; k < 5; k++) begin
      check("stream_no_dup", 32'(out_valid), 0);
      cycle();
    end
    out_ready = 1'b0;
    check("stream_idle", 32'(busy), 0);

    // ---- reset mid-flight with 3 outstanding ----
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_vec(i, 4'(12 + i));
      cycle();
    end
    in_valid = 1'b0;
    check("mid_issue_before", 32'(pipe_issue), 1);
    check("mid_busy_before",  32'(busy),       1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_in_ready",   32'(in_ready),   0);
    check("mid_pipe_issue", 32'(pipe_issue), 0);
    check("mid_out_valid",  32'(out_valid),  0);
    check("mid_busy",       32'(busy),       0);
    check("mid_arg0",       32'(pipe_arg_0), 0);
    check("mid_arg1",       32'(pipe_arg_1), 0);
    check("mid_arg2",       32'(pipe_arg_2), 0);
    check("mid_out_data",   32'(out_data),   0);
    check("mid_out_tag",    32'(out_tag),    0);
    #10;
    rst = 1'b0;
    #1;
    check("mid_rel_ready", 32'(in_ready), 1);
    for (int k = 0; k < 12; k++) begin
      cycle();
      check("mid_no_late", 32'(out_valid), 0);
    end
    check("mid_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
